// File: rtl/hamming_secded_codec.sv
// Hamming SEC-DED codec: independent encode and decode channels, each with a
// single registered output stage, plus saturating corrected/uncorrectable counters.
module hamming_secded_codec #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W = (DATA_W <= 4)  ? 3 :
                                  (DATA_W <= 11) ? 4 :
                                  (DATA_W <= 26) ? 5 : 6,
  localparam int unsigned N     = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_in_valid,
  output logic              enc_in_ready,
  input  logic [DATA_W-1:0] enc_data,
  output logic              enc_out_valid,
  input  logic              enc_out_ready,
  output logic [N-1:0]      enc_code,
  input  logic              dec_in_valid,
  output logic              dec_in_ready,
  input  logic [N-1:0]      dec_code,
  output logic              dec_out_valid,
  input  logic              dec_out_ready,
  output logic [DATA_W-1:0] dec_data,
  output logic [PAR_W-1:0]  dec_syndrome,
  output logic              dec_sec,
  output logic              dec_ded,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  function automatic logic is_pow2(input int unsigned p);
    return (p & (p - 1)) == 0;
  endfunction

  // Place payload bits at the non-power-of-two positions, data[0] at position 3.
  function automatic logic [N-1:0] spread_data(input logic [DATA_W-1:0] d);
    logic [N-1:0] w;
    int unsigned  k;
    w = '0;
    k = 0;
    for (int unsigned p = 3; p < N; p++) begin
      if (!is_pow2(p)) begin
        w = w | (N'((d >> k) & DATA_W'(1)) << p);
        k++;
      end
    end
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] gather_data(input logic [N-1:0] w);
    logic [DATA_W-1:0] d;
    int unsigned       k;
    d = '0;
    k = 0;
    for (int unsigned p = 3; p < N; p++) begin
      if (!is_pow2(p)) begin
        d = d | (DATA_W'((w >> p) & N'(1)) << k);
        k++;
      end
    end
    return d;
  endfunction

  // XOR of the indices of all set bits in positions 1..N-1.
  function automatic logic [PAR_W-1:0] syndrome(input logic [N-1:0] w);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int unsigned p = 1; p < N; p++) begin
      if (((w >> p) & N'(1)) != '0) s = s ^ PAR_W'(p);
    end
    return s;
  endfunction

  // Parity bit 2^j equals bit j of the data-only syndrome, which zeroes the full syndrome.
  function automatic logic [N-1:0] encode(input logic [DATA_W-1:0] d);
    logic [N-1:0]     w;
    logic [PAR_W-1:0] s;
    w = spread_data(d);
    s = syndrome(w);
    for (int unsigned j = 0; j < PAR_W; j++) begin
      w = w | (N'((s >> j) & PAR_W'(1)) << (32'd1 << j));
    end
    w = w | N'(^w);
    return w;
  endfunction

  logic              enc_valid_q, enc_valid_d;
  logic [N-1:0]      enc_code_q, enc_code_d;
  logic              dec_valid_q, dec_valid_d;
  logic [DATA_W-1:0] dec_data_q, dec_data_d;
  logic [PAR_W-1:0]  dec_syn_q, dec_syn_d;
  logic              dec_sec_q, dec_sec_d;
  logic              dec_ded_q, dec_ded_d;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;

  logic              enc_fire_c, dec_fire_c;
  logic [PAR_W-1:0]  dec_syn_c;
  logic              dec_par_c, dec_in_range_c, dec_sec_c, dec_ded_c;
  logic [N-1:0]      dec_fix_c;

  assign enc_in_ready = !enc_valid_q || enc_out_ready;
  assign dec_in_ready = !dec_valid_q || dec_out_ready;
  assign enc_fire_c   = enc_in_valid && enc_in_ready;
  assign dec_fire_c   = dec_in_valid && dec_in_ready;

  // Classify the received word; a syndrome beyond N-1 names no real bit.
  assign dec_syn_c      = syndrome(dec_code);
  assign dec_par_c      = ^dec_code;
  assign dec_in_range_c = 32'(dec_syn_c) < N;
  assign dec_sec_c      = dec_par_c && dec_in_range_c;
  assign dec_ded_c      = dec_par_c ? !dec_in_range_c : (dec_syn_c != '0);
  assign dec_fix_c      = dec_code ^ (dec_sec_c ? (N'(1) << dec_syn_c) : '0);

  always_comb begin
    enc_valid_d = enc_valid_q;
    enc_code_d  = enc_code_q;
    dec_valid_d = dec_valid_q;
    dec_data_d  = dec_data_q;
    dec_syn_d   = dec_syn_q;
    dec_sec_d   = dec_sec_q;
    dec_ded_d   = dec_ded_q;
    sec_cnt_d   = sec_cnt_q;
    ded_cnt_d   = ded_cnt_q;

    if (enc_fire_c) begin
      enc_valid_d = 1'b1;
      enc_code_d  = encode(enc_data);
    end else if (enc_out_ready) begin
      enc_valid_d = 1'b0;
    end

    if (dec_fire_c) begin
      dec_valid_d = 1'b1;
      dec_data_d  = gather_data(dec_fix_c);
      dec_syn_d   = dec_syn_c;
      dec_sec_d   = dec_sec_c;
      dec_ded_d   = dec_ded_c;
    end else if (dec_out_ready) begin
      dec_valid_d = 1'b0;
    end

    // Clear dominates a same-cycle increment; counters stick at all-ones.
    if (clr_cnt) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (dec_fire_c) begin
      if (dec_sec_c && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (dec_ded_c && ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_valid_q <= 1'b0;
      enc_code_q  <= '0;
      dec_valid_q <= 1'b0;
      dec_data_q  <= '0;
      dec_syn_q   <= '0;
      dec_sec_q   <= 1'b0;
      dec_ded_q   <= 1'b0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
    end else begin
      enc_valid_q <= enc_valid_d;
      enc_code_q  <= enc_code_d;
      dec_valid_q <= dec_valid_d;
      dec_data_q  <= dec_data_d;
      dec_syn_q   <= dec_syn_d;
      dec_sec_q   <= dec_sec_d;
      dec_ded_q   <= dec_ded_d;
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
    end
  end

  assign enc_out_valid = enc_valid_q;
  assign enc_code      = enc_code_q;
  assign dec_out_valid = dec_valid_q;
  assign dec_data      = dec_data_q;
  assign dec_syndrome  = dec_syn_q;
  assign dec_sec       = dec_sec_q;
  assign dec_ded       = dec_ded_q;
  assign sec_cnt       = sec_cnt_q;
  assign ded_cnt       = ded_cnt_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Bench for hamming_secded_codec (DATA_W=4, CNT_W=2): directed literal cases,
// then randomized traffic compared every cycle against an array-based Hamming model.
module tb_hamming_secded_codec;

  localparam int unsigned DW   = 4;
  localparam int unsigned NW   = 8;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enc_in_valid, enc_in_ready, enc_out_valid, enc_out_ready;
  logic [DW-1:0] enc_data;
  logic [NW-1:0] enc_code;
  logic          dec_in_valid, dec_in_ready, dec_out_valid, dec_out_ready;
  logic [NW-1:0] dec_code;
  logic [DW-1:0] dec_data;
  logic [2:0]    dec_syndrome;
  logic          dec_sec, dec_ded, clr_cnt;
  logic [CW-1:0] sec_cnt, ded_cnt;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  hamming_secded_codec #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .enc_in_valid(enc_in_valid), .enc_in_ready(enc_in_ready), .enc_data(enc_data),
    .enc_out_valid(enc_out_valid), .enc_out_ready(enc_out_ready), .enc_code(enc_code),
    .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready), .dec_code(dec_code),
    .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready), .dec_data(dec_data),
    .dec_syndrome(dec_syndrome), .dec_sec(dec_sec), .dec_ded(dec_ded),
    .clr_cnt(clr_cnt), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference encoder built straight from the positional parity definition.
  function automatic logic [7:0] ref_enc(input logic [3:0] d);
    int b[8];
    int dpos[4];
    int par;
    logic [7:0] c;
    dpos = '{3, 5, 6, 7};
    for (int p = 0; p < 8; p++) b[p] = 0;
    for (int i = 0; i < 4; i++) b[dpos[i]] = int'((d >> i) & 4'd1);
    for (int j = 0; j < 3; j++) begin
      par = 0;
      for (int p = 1; p < 8; p++)
        if (((p >> j) & 1) == 1 && p != (1 << j)) par ^= b[p];
      b[1 << j] = par;
    end
    b[0] = 0;
    for (int p = 1; p < 8; p++) b[0] ^= b[p];
    c = '0;
    for (int p = 0; p < 8; p++) c = c | (8'(b[p]) << p);
    return c;
  endfunction

  function automatic void ref_dec(input logic [7:0] c, output logic [3:0] d,
                                  output logic [2:0] s, output logic sec, output logic ded);
    int b[8];
    int dpos[4];
    int sv, g;
    dpos = '{3, 5, 6, 7};
    sv = 0;
    g  = 0;
    for (int p = 0; p < 8; p++) begin
      b[p] = int'((c >> p) & 8'd1);
      g ^= b[p];
      if (p > 0 && b[p] == 1) sv ^= p;
    end
    sec = 1'b0;
    ded = 1'b0;
    if (g == 1 && sv == 0) sec = 1'b1;
    else if (g == 1 && sv < int'(NW)) begin
      b[sv] ^= 1;
      sec = 1'b1;
    end else if (g == 1 || sv != 0) ded = 1'b1;
    d = '0;
    for (int i = 0; i < 4; i++) d = d | (4'(b[dpos[i]]) << i);
    s = 3'(sv);
  endfunction

  function automatic logic [7:0] gen_code();
    logic [7:0] c;
    int a, b;
    c = ref_enc(4'($urandom));
    case ($urandom_range(0, 3))
      1: c = c ^ (8'(1) << $urandom_range(0, 7));
      2: begin
        a = int'($urandom_range(0, 7));
        b = (a + int'($urandom_range(1, 7))) % 8;
        c = c ^ (8'(1) << a) ^ (8'(1) << b);
      end
      3: c = 8'($urandom);
      default: ;
    endcase
    return c;
  endfunction

  // Model state: what each output register must hold.
  logic       mev = 1'b0;
  logic [7:0] mcode = '0;
  logic       mdv = 1'b0;
  logic [3:0] mdd = '0;
  logic [2:0] mds = '0;
  logic       msec = 1'b0, mded = 1'b0;
  int         msc = 0, mdc = 0;

  always @(negedge clk) begin : compare
    logic [3:0] nd;
    logic [2:0] ns;
    logic nsec, nded, efire, dfire;
    if (check_en) begin
      chk("enc_in_ready",  enc_in_ready,  !mev || enc_out_ready);
      chk("enc_out_valid", enc_out_valid, mev);
      chk("enc_code",      enc_code,      mcode);
      chk("dec_in_ready",  dec_in_ready,  !mdv || dec_out_ready);
      chk("dec_out_valid", dec_out_valid, mdv);
      chk("dec_data",      dec_data,      mdd);
      chk("dec_syndrome",  dec_syndrome,  mds);
      chk("dec_sec",       dec_sec,       msec);
      chk("dec_ded",       dec_ded,       mded);
      chk("sec_cnt",       sec_cnt,       msc);
      chk("ded_cnt",       ded_cnt,       mdc);
    end
    efire = enc_in_valid && (!mev || enc_out_ready);
    dfire = dec_in_valid && (!mdv || dec_out_ready);
    ref_dec(dec_code, nd, ns, nsec, nded);
    if (rst) begin
      mev = 1'b0; mcode = '0; mdv = 1'b0; mdd = '0; mds = '0;
      msec = 1'b0; mded = 1'b0; msc = 0; mdc = 0;
    end else begin
      if (efire) begin
        mev = 1'b1;
        mcode = ref_enc(enc_data);
      end else if (enc_out_ready) mev = 1'b0;
      if (dfire) begin
        mdv = 1'b1; mdd = nd; mds = ns; msec = nsec; mded = nded;
      end else if (dec_out_ready) mdv = 1'b0;
      if (clr_cnt) begin
        msc = 0;
        mdc = 0;
      end else if (dfire) begin
        if (nsec && msc < CMAX) msc++;
        if (nded && mdc < CMAX) mdc++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dec_one(input logic [7:0] c);
    cyc();
    dec_code = c;
    dec_in_valid = 1'b1;
    cyc();
    dec_in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    logic ef, df, wasrst;
    rst = 1'b1; clr_cnt = 1'b0;
    enc_in_valid = 1'b0; enc_data = '0; enc_out_ready = 1'b1;
    dec_in_valid = 1'b0; dec_code = '0; dec_out_ready = 1'b1;
    cyc();
    check_en = 1'b1;
    rst = 1'b0;

    // Clean round trip of 4'b1011 on both channels.
    enc_data = 4'b1011; enc_in_valid = 1'b1;
    dec_code = 8'hAA;   dec_in_valid = 1'b1;
    cyc();
    enc_in_valid = 1'b0; dec_in_valid = 1'b0;
    @(negedge clk);
    chk("lit_enc_code", enc_code, 8'hAA);
    chk("lit_enc_valid", enc_out_valid, 1);
    chk("lit_aa_data", dec_data, 4'b1011);
    chk("lit_aa_syn", dec_syndrome, 0);
    chk("lit_aa_flags", {dec_sec, dec_ded}, 2'b00);

    dec_one(8'h8A);
    chk("lit_8a_data", dec_data, 4'b1011);
    chk("lit_8a_syn", dec_syndrome, 5);
    chk("lit_8a_sec", dec_sec, 1);
    chk("lit_8a_cnt", sec_cnt, 1);

    dec_one(8'hAB);
    chk("lit_ab_data", dec_data, 4'b1011);
    chk("lit_ab_syn", dec_syndrome, 0);
    chk("lit_ab_sec", dec_sec, 1);

    dec_one(8'h82);
    chk("lit_82_syn", dec_syndrome, 6);
    chk("lit_82_ded", {dec_sec, dec_ded}, 2'b01);
    chk("lit_82_data", dec_data, 4'b1000);
    chk("lit_82_cnt", ded_cnt, 1);

    // Backpressure: one load, then a stall with input held.
    cyc(); clr_cnt = 1'b1;
    cyc(); clr_cnt = 1'b0;
    dec_out_ready = 1'b0; dec_code = 8'h8A; dec_in_valid = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", dec_in_ready, 0);
      chk("bp_valid", dec_out_valid, 1);
      chk("bp_syn", dec_syndrome, 5);
      chk("bp_cnt", sec_cnt, 1);
      cyc();
    end
    dec_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      dec_code = (i % 2 == 0) ? 8'hAB : 8'h82;
      @(negedge clk);
      chk("stream_valid", dec_out_valid, 1);
      chk("stream_ready", dec_in_ready, 1);
    end
    cyc(); dec_in_valid = 1'b0;

    // Saturation, then clear colliding with an increment.
    cyc(); clr_cnt = 1'b1;
    cyc(); clr_cnt = 1'b0; dec_code = 8'h8A; dec_in_valid = 1'b1;
    repeat (5) cyc();
    dec_in_valid = 1'b0;
    @(negedge clk);
    chk("sat_cnt", sec_cnt, 3);
    cyc(); clr_cnt = 1'b1;
    cyc(); clr_cnt = 1'b0; dec_in_valid = 1'b1;
    cyc(); clr_cnt = 1'b1;
    cyc(); clr_cnt = 1'b0; dec_in_valid = 1'b0;
    @(negedge clk);
    chk("clr_win_cnt", sec_cnt, 0);
    chk("clr_win_sec", dec_sec, 1);

    // Reset while words are held and new inputs are presented.
    cyc();
    enc_out_ready = 1'b0; dec_out_ready = 1'b0;
    enc_data = 4'hF; enc_in_valid = 1'b1; dec_code = 8'h8A; dec_in_valid = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; enc_in_valid = 1'b0; dec_in_valid = 1'b0;
    @(negedge clk);
    chk("rst_enc", {enc_out_valid, enc_code}, 0);
    chk("rst_dec", {dec_out_valid, dec_data, dec_syndrome, dec_sec, dec_ded}, 0);
    chk("rst_cnt", {sec_cnt, ded_cnt}, 0);
    chk("rst_ready", {enc_in_ready, dec_in_ready}, 2'b11);
    enc_out_ready = 1'b1; dec_out_ready = 1'b1;

    // Randomized traffic; inputs are held while stalled.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ef = enc_in_valid && enc_in_ready;
      df = dec_in_valid && dec_in_ready;
      wasrst = rst;
      cyc();
      if (!enc_in_valid || ef || wasrst) begin
        enc_in_valid = ($urandom_range(0, 3) != 0);
        enc_data = 4'($urandom);
      end
      if (!dec_in_valid || df || wasrst) begin
        dec_in_valid = ($urandom_range(0, 3) != 0);
        dec_code = gen_code();
      end
      enc_out_ready = ($urandom_range(0, 3) != 0);
      dec_out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
